// File: rtl/debug_cmd_rx.sv
// Debug link receiver: 8N1 UART deserializer feeding a single-letter command parser (halt/continue/step/breakpoint).
// Commands take effect one cycle after rx_valid; no backpressure, each byte is consumed as it arrives.
module debug_cmd_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic [15:0] pc,
  output logic        halt,
  output logic        step,
  output logic        bp_en,
  output logic [15:0] bp_addr,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        cmd_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_HEX, P_TERM} p_state_t;

  rx_state_t       r_state;
  p_state_t        p_state;
  logic            rx_s1, rx_s2, rx_prev;
  logic [1:0]      sync_fill;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            frm_err, syn_err;
  logic [15:0]     hex_sh;
  logic [2:0]      digits;
  logic [15:0]     pc_q;
  logic            bp_match;

  function automatic logic is_hex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) ||
           (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  // rx_prev stays low until the synchronizer holds real line samples, so a
  // line that is already low at reset release is not taken as a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      sync_fill <= 2'b00;
      rx_prev   <= 1'b0;
      r_state   <= R_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_byte   <= 8'h00;
      rx_valid  <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rx_s1     <= rx;
      rx_s2     <= rx_s1;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= sync_fill[1] & rx_s2;
      rx_valid  <= 1'b0;
      frm_err   <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            r_state <= R_START;
            cnt     <= '0;
          end
        end
        R_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s2) begin
              r_state <= R_IDLE;
            end else begin
              r_state <= R_DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx_s2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) r_state <= R_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            r_state <= R_IDLE;
            if (rx_s2) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              frm_err  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Edge-qualified so that continuing from a breakpoint does not re-halt.
  assign bp_match = bp_en & (pc == bp_addr) & (pc != pc_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_state <= P_IDLE;
      hex_sh  <= 16'h0000;
      digits  <= 3'd0;
      halt    <= 1'b0;
      step    <= 1'b0;
      bp_en   <= 1'b0;
      bp_addr <= 16'h0000;
      syn_err <= 1'b0;
      pc_q    <= 16'h0000;
    end else begin
      pc_q    <= pc;
      step    <= 1'b0;
      syn_err <= 1'b0;
      if (rx_valid) begin
        case (p_state)
          P_IDLE: begin
            case (rx_byte)
              8'h48, 8'h68: halt  <= 1'b1;
              8'h43, 8'h63: halt  <= 1'b0;
              8'h53, 8'h73: step  <= halt;
              8'h58, 8'h78: bp_en <= 1'b0;
              8'h42, 8'h62: begin
                hex_sh  <= 16'h0000;
                digits  <= 3'd0;
                p_state <= P_HEX;
              end
              8'h20, 8'h0D, 8'h0A: ;
              default: syn_err <= 1'b1;
            endcase
          end
          P_HEX: begin
            if (is_hex(rx_byte)) begin
              hex_sh <= {hex_sh[11:0], hex_val(rx_byte)};
              digits <= digits + 3'd1;
              if (digits == 3'd3) p_state <= P_TERM;
            end else begin
              syn_err <= 1'b1;
              p_state <= P_IDLE;
            end
          end
          P_TERM: begin
            if (rx_byte == 8'h0D || rx_byte == 8'h0A) begin
              bp_addr <= hex_sh;
              bp_en   <= 1'b1;
            end else begin
              syn_err <= 1'b1;
            end
            p_state <= P_IDLE;
          end
          default: p_state <= P_IDLE;
        endcase
      end
      // Breakpoint hit overrides a same-cycle continue.
      if (bp_match) halt <= 1'b1;
    end
  end

  assign cmd_err = frm_err | syn_err;

endmodule
